// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_S AXI4-Stream slaves onto one master, grant held until tlast.
// Optional macro AXIS_PKT_RR_ARB_TID_EN adds m_axis_tid carrying the source index.
module axis_pkt_rr_arbiter #(
  parameter int unsigned NUM_S  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 1,
  localparam int unsigned GRANT_W = $clog2(NUM_S)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_S*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_S*USER_W-1:0]   s_axis_tuser,
  input  logic [NUM_S-1:0]          s_axis_tlast,
  input  logic [NUM_S-1:0]          s_axis_tvalid,
  output logic [NUM_S-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [USER_W-1:0]         m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
`ifdef AXIS_PKT_RR_ARB_TID_EN
  output logic [GRANT_W-1:0]        m_axis_tid,
`endif
  output logic                      arb_busy,
  output logic [GRANT_W-1:0]        arb_grant
);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic               state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] pick;
  logic               busy;
  logic               release_pkt;

  assign busy = (state_q == StBusy);
  assign release_pkt = busy && s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q];

  // Scan downward so the last hit is the nearest requester after rr_ptr.
  always_comb begin
    pick = '0;
    for (int unsigned i = NUM_S; i >= 1; i--) begin
      logic [GRANT_W-1:0] cand;
      cand = GRANT_W'((32'(rr_ptr_q) + i) % NUM_S);
      if (s_axis_tvalid[cand]) begin
        pick = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle) begin
      if (|s_axis_tvalid) begin
        grant_d = pick;
        state_d = StBusy;
      end
    end else begin
      if (release_pkt) begin
        rr_ptr_d = grant_q;
        state_d  = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= GRANT_W'(NUM_S - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    s_axis_tready          = '0;
    s_axis_tready[grant_q] = busy & m_axis_tready;
  end

  assign m_axis_tvalid = busy & s_axis_tvalid[grant_q];
  assign m_axis_tdata  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
  assign m_axis_tuser  = s_axis_tuser[grant_q*USER_W +: USER_W];
  assign m_axis_tlast  = s_axis_tlast[grant_q];
  assign arb_busy      = busy;
  assign arb_grant     = grant_q;

`ifdef AXIS_PKT_RR_ARB_TID_EN
  assign m_axis_tid = busy ? grant_q : '0;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench for axis_pkt_rr_arbiter: packet queues per port, cycle model of the
// round-robin rules, per-cycle output compare, plus literal grant-order/timing expectations.
module tb_axis_pkt_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int UW = 1;
  localparam int GW = 2;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS*UW-1:0]  s_axis_tuser;
  logic [NS-1:0]     s_axis_tlast;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              arb_busy;
  logic [GW-1:0]     arb_grant;
`ifdef AXIS_PKT_RR_ARB_TID_EN
  logic [GW-1:0]     m_axis_tid;
`endif

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter #(.NUM_S(NS), .DATA_W(DW), .USER_W(UW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef AXIS_PKT_RR_ARB_TID_EN
    .m_axis_tid    (m_axis_tid),
`endif
    .arb_busy      (arb_busy),
    .arb_grant     (arb_grant)
  );

  // Per-port beat stores (ring buffers) shared by driver and model.
  logic [DW-1:0] mdat [NS][DEPTH];
  logic          mlst [NS][DEPTH];
  int            mgap [NS][DEPTH];
  int            wr [NS];
  int            rd [NS];
  int            pkt_no [NS];

  int total, bad, cyc;
  int mo, ml, mg;  // owner (-1 idle), last released port, grant register
  int glog_p[$], glog_c[$], blog_p[$], blog_c[$];
  logic rdy_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int n, input int gap_beat, input int gap_len);
    for (int b = 0; b < n; b++) begin
      int h;
      h = wr[p] % DEPTH;
      mdat[p][h] = {16'hA5A5, 16'(p), 16'(pkt_no[p]), 16'(b)};
      mlst[p][h] = (b == n - 1);
      mgap[p][h] = (b == gap_beat) ? gap_len : 0;
      wr[p]++;
    end
    pkt_no[p]++;
  endtask

  function automatic int pick(input logic [NS-1:0] v);
    for (int k = 1; k <= NS; k++) begin
      int p;
      p = (ml + k) % NS;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic int gl(input int i);
    return (i < glog_p.size()) ? glog_p[i] : -1;
  endfunction

  function automatic int gc(input int i);
    return (i < glog_c.size()) ? glog_c[i] : -1000;
  endfunction

  function automatic int beat_cyc(input int p, input int n);
    int c;
    c = 0;
    foreach (blog_p[i]) begin
      if (blog_p[i] == p) begin
        if (c == n) return blog_c[i];
        c++;
      end
    end
    return -1000;
  endfunction

  function automatic int beats_of(input int p);
    int c;
    c = 0;
    foreach (blog_p[i]) if (blog_p[i] == p) c++;
    return c;
  endfunction

  task automatic clear_logs();
    glog_p.delete(); glog_c.delete(); blog_p.delete(); blog_c.delete();
  endtask

  task automatic drive();
    for (int p = 0; p < NS; p++) begin
      if (rd[p] != wr[p]) begin
        int h;
        h = rd[p] % DEPTH;
        s_axis_tdata[p*DW +: DW] = mdat[p][h];
        s_axis_tuser[p] = mdat[p][h][0];
        s_axis_tlast[p] = mlst[p][h];
        if (mgap[p][h] > 0) begin
          s_axis_tvalid[p] = 1'b0;
          mgap[p][h]--;
        end else begin
          s_axis_tvalid[p] = 1'b1;
        end
      end else begin
        s_axis_tdata[p*DW +: DW] = '0;
        s_axis_tuser[p] = 1'b0;
        s_axis_tlast[p] = 1'b0;
        s_axis_tvalid[p] = 1'b0;
      end
    end
    m_axis_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
  endtask

  task automatic check();
    logic busy_e, tv_e;
    logic [NS-1:0] tr_e;
    busy_e = (mo >= 0);
    tv_e = busy_e ? s_axis_tvalid[mo] : 1'b0;
    tr_e = (busy_e && m_axis_tready) ? NS'(1 << mo) : '0;
    chk("busy", 64'(arb_busy), 64'(busy_e));
    chk("grant", 64'(arb_grant), 64'(mg));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(tv_e));
    chk("s_tready", 64'(s_axis_tready), 64'(tr_e));
`ifdef AXIS_PKT_RR_ARB_TID_EN
    chk("tid", 64'(m_axis_tid), busy_e ? 64'(mg) : 64'(0));
`endif
    if (tv_e) begin
      int h;
      h = rd[mo] % DEPTH;
      chk("m_tdata", m_axis_tdata, mdat[mo][h]);
      chk("m_tlast", 64'(m_axis_tlast), 64'(mlst[mo][h]));
      chk("m_tuser", 64'(m_axis_tuser), 64'(mdat[mo][h][0]));
    end
  endtask

  task automatic update();
    if (mo < 0) begin
      int p;
      p = pick(s_axis_tvalid);
      if (p >= 0) begin
        mo = p;
        mg = p;
        glog_p.push_back(p);
        glog_c.push_back(cyc);
      end
    end else if (s_axis_tvalid[mo] && m_axis_tready) begin
      int h;
      logic lst;
      h = rd[mo] % DEPTH;
      lst = mlst[mo][h];
      blog_p.push_back(mo);
      blog_c.push_back(cyc);
      rd[mo]++;
      if (lst) begin
        ml = mo;
        mo = -1;
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check();
    update();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset (asynchronously), checks idle outputs, flushes everything.
  task automatic hw_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_busy"}, 64'(arb_busy), 64'(0));
    chk({tag, "_grant"}, 64'(arb_grant), 64'(0));
    chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'(0));
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'(0));
    for (int p = 0; p < NS; p++) rd[p] = wr[p];
    rdy_q.delete();
    mo = -1; ml = NS - 1; mg = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e2[8];
    int e3[4];
    e2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    e3 = '{1, 4, 5, 6};
    total = 0; bad = 0; cyc = 0;
    for (int p = 0; p < NS; p++) begin wr[p] = 0; rd[p] = 0; pkt_no[p] = 0; end
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = '0; s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    rst_n = 1'b1;
    #1;
    hw_reset("por");

    // Ports 0 and 2 with 3-beat packets: 0 first, one idle cycle, then 2.
    add_pkt(0, 3, -1, 0);
    add_pkt(2, 3, -1, 0);
    repeat (10) step();
    chki("t1_ngrant", glog_p.size(), 2);
    chki("t1_first", gl(0), 0);
    chki("t1_second", gl(1), 2);
    chki("t1_gap", beat_cyc(2, 0) - beat_cyc(0, 0), 4);
    chki("t1_beats", blog_p.size(), 6);

    // All four ports, two 2-beat packets each: strict rotation, 3 cycles per packet.
    hw_reset("t2rst");
    clear_logs();
    for (int k = 0; k < 2; k++) for (int p = 0; p < NS; p++) add_pkt(p, 2, -1, 0);
    repeat (26) step();
    chki("t2_ngrant", glog_p.size(), 8);
    for (int i = 0; i < 8; i++) chki("t2_order", gl(i), e2[i]);
    for (int i = 0; i < 7; i++) chki("t2_spacing", gc(i + 1) - gc(i), 3);

    // Port 1, 4 beats, tready 1,0,0,1,1,1 during BUSY (leading 1 is the IDLE cycle).
    clear_logs();
    add_pkt(1, 4, -1, 0);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    repeat (10) step();
    chki("t3_grant", gl(0), 1);
    chki("t3_nbeats", beats_of(1), 4);
    for (int k = 0; k < 4; k++) chki("t3_beat_off", beat_cyc(1, k) - gc(0), e3[k]);

    // Port 3 single beat beats waiting port 0 (ptr=1); port 0 then has a 2-cycle gap before tlast.
    clear_logs();
    add_pkt(0, 2, 1, 2);
    add_pkt(3, 1, -1, 0);
    repeat (10) step();
    chki("t4_first", gl(0), 3);
    chki("t4_second", gl(1), 0);
    chki("t4_p0_after_p3", beat_cyc(0, 0) - beat_cyc(3, 0), 2);
    chki("t4_gap_held", beat_cyc(0, 1) - beat_cyc(0, 0), 3);

    // Reset during beat 2 of port 2's 5-beat packet, then 0 wins among 0,2,3.
    hw_reset("t5pre");
    clear_logs();
    add_pkt(2, 5, -1, 0);
    step();
    step();
    drive();
    @(negedge clk);
    check();
    hw_reset("t5mid");
    clear_logs();
    add_pkt(2, 2, -1, 0);
    add_pkt(0, 2, -1, 0);
    add_pkt(3, 2, -1, 0);
    repeat (12) step();
    chki("t5_first", gl(0), 0);
    chki("t5_second", gl(1), 2);
    chki("t5_third", gl(2), 3);

    // Ports 1 and 2 one packet each (source index visible on tid when enabled).
    clear_logs();
    add_pkt(1, 2, -1, 0);
    add_pkt(2, 2, -1, 0);
    repeat (8) step();
    chki("t6_first", gl(0), 1);
    chki("t6_second", gl(1), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
